// File: rtl/rv_pkg.sv
// rv_pkg: shared ready/valid bus constants and payload type
// Used by rv_fifo and by the bus interface it feeds.
package rv_pkg;
   localparam int RV_DATA_W = 8;
   typedef logic [RV_DATA_W-1:0] rv_data_t;
endpackage

// File: rtl/rv_fifo_mem.sv
// rv_fifo_mem: DEPTH x DATA_W register array, sync write, async read, sync clear
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset, clears every entry to 0
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  combinational read data at raddr_i
module rv_fifo_mem import rv_pkg::*; #(
   parameter int DATA_W = RV_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   // Reset has priority so a write attempted on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rv_fifo.sv
// rv_fifo: synchronous ready/valid FIFO with show-ahead output
// Ports:
//   clk      clock, all state changes on posedge
//   rst_n    synchronous active-low reset
//   s_data   upstream payload
//   s_valid  upstream offers s_data
//   s_ready  FIFO accepts a byte this cycle
//   m_data   head-of-queue payload
//   m_valid  m_data holds a valid byte
//   m_ready  downstream accepts m_data this cycle
//   count    current occupancy, 0..DEPTH
module rv_fifo import rv_pkg::*; #(
   parameter int DATA_W = RV_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rdy_q, push, pop;
   // Handshake outputs come only from registered state; no pass-through when
   // full and no bypass when empty.
   assign s_ready = rdy_q && (count_q != FULL);
   assign m_valid = (count_q != '0);
   assign count   = count_q;
   always_comb begin
      push     = s_valid && s_ready;
      pop      = m_valid && m_ready;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   // rdy_q holds s_ready low during reset and rises on the first released edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdy_q    <= 1'b1;
      end
   end
   rv_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (s_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (m_data)
   );
endmodule

// File: tb/tb_rv_fifo.sv
// tb_rv_fifo: directed plus randomized checks of rv_fifo against a queue model
module tb_rv_fifo;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst_n, s_valid, s_ready, m_valid, m_ready;
   logic [7:0] s_data, m_data;
   logic [2:0] count;
   int checks = 0, failures = 0;
   logic [7:0] q[$];
   bit         rdy_m = 1'b0;

   rv_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model by the FIFO rules, then compare.
   task automatic step(input bit rst, input bit sv, input logic [7:0] sd, input bit mr);
      bit push, pop;
      rst_n = !rst; s_valid = sv; s_data = sd; m_ready = mr;
      push = sv && rdy_m && (q.size() < DEPTH);
      pop  = mr && (q.size() > 0);
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         rdy_m = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(sd);
         rdy_m = 1'b1;
      end
      chk("count", int'(count), q.size());
      chk("m_valid", int'(m_valid), int'(q.size() != 0));
      chk("s_ready", int'(s_ready), int'(rdy_m && q.size() != DEPTH));
      if (q.size() != 0) chk("m_data", int'(m_data), int'(q[0]));
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      // reset then idle
      step(1, 0, 8'h00, 0);
      step(1, 1, 8'h77, 1);
      chk("rst_m_data", int'(m_data), 0);
      step(0, 0, 8'h00, 0);
      chk("release_s_ready", int'(s_ready), 1);
      chk("empty_m_data", int'(m_data), 0);
      // single byte
      step(0, 1, 8'hA5, 0);
      chk("single_data", int'(m_data), 'hA5);
      step(0, 0, 8'h00, 1);
      chk("single_drained", int'(m_valid), 0);
      // fill to full, extra byte refused
      for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0);
      chk("full_count", int'(count), 4);
      step(0, 1, 8'h05, 0);
      chk("full_refuse", int'(s_ready), 0);
      // full with simultaneous ready: pop only
      chk("full_head", int'(m_data), 'h01);
      step(0, 1, 8'h05, 1);
      chk("full_pop_count", int'(count), 3);
      chk("full_pop_head", int'(m_data), 'h02);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
      chk("drained", int'(m_valid), 0);
      // streaming with wrap
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 8'(8'h10 + i), 1);
         chk("stream_count", int'(count), 1);
         chk("stream_data", int'(m_data), 'h10 + i);
      end
      step(0, 0, 8'h00, 1);
      // reset mid-stream at count 3
      for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hC0 + i), 0);
      chk("pre_rst_count", int'(count), 3);
      step(1, 1, 8'hEE, 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_valid", int'(m_valid), 0);
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'h5A, 0);
      chk("post_rst_data", int'(m_data), 'h5A);
      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
              8'($urandom), $urandom_range(0, 2) != 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
